// File: rtl/wb_regfile_pkg.sv
// Shared constants and write-back source selection for the WB stage.
package wb_regfile_pkg;

  localparam int DATA_W      = 32;
  localparam int ADDR_W      = 5;
  localparam int LINK_OFFSET = 8;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'd0,
    WB_SEL_MEM  = 2'd1,
    WB_SEL_LINK = 2'd2
  } wb_sel_e;

  // Link beats load, load beats ALU.
  function automatic wb_sel_e wb_sel_f(input logic datac, input logic memto);
    if (datac)      return WB_SEL_LINK;
    else if (memto) return WB_SEL_MEM;
    else            return WB_SEL_ALU;
  endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// MEM->WB input bundle, ID read ports and forwarding outputs of the WB stage.
interface wb_regfile_if
  import wb_regfile_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W,
  parameter int CW = 32
);

  logic [AW-1:0] write_reg_wb;
  logic [DW-1:0] AluResWb;
  logic [DW-1:0] read_data_wb;
  logic [DW-1:0] pc_wb;
  logic          MemtoRegWb;
  logic          DatacWb;
  logic          RegwriteWb;
  logic [AW-1:0] rs_addr;
  logic [AW-1:0] rt_addr;
  logic [DW-1:0] rs_data;
  logic [DW-1:0] rt_data;
  logic          wb_en;
  logic [AW-1:0] wb_reg;
  logic [DW-1:0] wb_data;
  logic [CW-1:0] wb_count;

  modport master (
    output write_reg_wb, AluResWb, read_data_wb, pc_wb,
    output MemtoRegWb, DatacWb, RegwriteWb, rs_addr, rt_addr,
    input  rs_data, rt_data, wb_en, wb_reg, wb_data, wb_count
  );

  modport slave (
    input  write_reg_wb, AluResWb, read_data_wb, pc_wb,
    input  MemtoRegWb, DatacWb, RegwriteWb, rs_addr, rt_addr,
    output rs_data, rt_data, wb_en, wb_reg, wb_data, wb_count
  );

endinterface

// File: rtl/wb_regfile_wb_mux.sv
// Combinational 3:1 write-back value select (link / load / ALU).
module wb_mux
  import wb_regfile_pkg::*;
#(
  parameter int DW     = DATA_W,
  parameter int LINK_O = LINK_OFFSET
) (
  input  logic          datac_i,
  input  logic          memto_i,
  input  logic [DW-1:0] alu_i,
  input  logic [DW-1:0] mem_i,
  input  logic [DW-1:0] pc_i,
  output logic [DW-1:0] wb_data_o
);

  wb_sel_e sel;

  assign sel = wb_sel_f(datac_i, memto_i);

  // Link value wraps naturally at DW bits.
  always_comb begin
    wb_data_o = alu_i;
    case (sel)
      WB_SEL_LINK: wb_data_o = pc_i + DW'(LINK_O);
      WB_SEL_MEM:  wb_data_o = mem_i;
      default:     wb_data_o = alu_i;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage and GPR file: commit, zero-latency read ports with
// same-cycle bypass, and a retired-write counter.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DW     = DATA_W,
  parameter int AW     = ADDR_W,
  parameter int LINK_O = LINK_OFFSET,
  parameter int CNT_W  = 32
) (
  input  logic clk,
  input  logic rst,
  wb_regfile_if.slave bus
);

  localparam int NREG = 1 << AW;

  // Flop array rather than a RAM macro so reset can clear every entry.
  logic [DW-1:0]    gpr_q [NREG];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [DW-1:0]    wb_data;
  logic             wb_en;
  logic [DW-1:0]    rs_data;
  logic [DW-1:0]    rt_data;

  wb_mux #(
    .DW     (DW),
    .LINK_O (LINK_O)
  ) u_wb_mux (
    .datac_i   (bus.DatacWb),
    .memto_i   (bus.MemtoRegWb),
    .alu_i     (bus.AluResWb),
    .mem_i     (bus.read_data_wb),
    .pc_i      (bus.pc_wb),
    .wb_data_o (wb_data)
  );

  // Writes to r0 are dropped, and reset suppresses the commit (and bypass).
  assign wb_en = bus.RegwriteWb & ~rst & (bus.write_reg_wb != AW'(REG_ZERO));
  assign cnt_d = wb_en ? cnt_q + CNT_W'(1) : cnt_q;

  // Read port A: r0 reads zero, a same-cycle commit is forwarded.
  always_comb begin
    rs_data = gpr_q[bus.rs_addr];
    if (bus.rs_addr == AW'(REG_ZERO))
      rs_data = '0;
    else if (wb_en && (bus.rs_addr == bus.write_reg_wb))
      rs_data = wb_data;
  end

  // Read port B: same rules as port A, fully independent.
  always_comb begin
    rt_data = gpr_q[bus.rt_addr];
    if (bus.rt_addr == AW'(REG_ZERO))
      rt_data = '0;
    else if (wb_en && (bus.rt_addr == bus.write_reg_wb))
      rt_data = wb_data;
  end

  // Commit to the array and count retired writes; reset wins over a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) gpr_q[i] <= '0;
      cnt_q <= '0;
    end else begin
      if (wb_en) gpr_q[bus.write_reg_wb] <= wb_data;
      cnt_q <= cnt_d;
    end
  end

  assign bus.rs_data  = rs_data;
  assign bus.rt_data  = rt_data;
  assign bus.wb_en    = wb_en;
  assign bus.wb_reg   = bus.write_reg_wb;
  assign bus.wb_data  = wb_data;
  assign bus.wb_count = cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed vector table, random traffic against an
// array model, and a narrow-counter instance for wrap behaviour.
module tb_wb_regfile;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  wb_regfile_if #(.DW(32), .AW(5), .CW(32)) bus  ();
  wb_regfile_if #(.DW(32), .AW(5), .CW(4))  bus4 ();

  wb_regfile #(.DW(32), .AW(5), .LINK_O(8), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  wb_regfile #(.DW(32), .AW(5), .LINK_O(8), .CNT_W(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  assign bus4.write_reg_wb = bus.write_reg_wb;
  assign bus4.AluResWb     = bus.AluResWb;
  assign bus4.read_data_wb = bus.read_data_wb;
  assign bus4.pc_wb        = bus.pc_wb;
  assign bus4.MemtoRegWb   = bus.MemtoRegWb;
  assign bus4.DatacWb      = bus.DatacWb;
  assign bus4.RegwriteWb   = bus.RegwriteWb;
  assign bus4.rs_addr      = bus.rs_addr;
  assign bus4.rt_addr      = bus.rt_addr;

  typedef struct {
    logic        rst, rw, memto, datac;
    logic [4:0]  wr, rs, rt;
    logic [31:0] alu, rd, pc;
    logic [31:0] e_rs, e_rt;
    logic        e_en;
    logic [31:0] e_data, e_cnt;
  } vec_t;

  int errors = 0;
  int checks = 0;

  logic [31:0] mdl [32];
  logic [31:0] mcnt;

  function automatic vec_t mk(input logic r, rw, memto, datac,
                              input logic [4:0] wr, rs, rt,
                              input logic [31:0] alu, rd, pc, e_rs, e_rt,
                              input logic e_en, input logic [31:0] e_data, e_cnt);
    vec_t v;
    v.rst = r; v.rw = rw; v.memto = memto; v.datac = datac;
    v.wr = wr; v.rs = rs; v.rt = rt;
    v.alu = alu; v.rd = rd; v.pc = pc;
    v.e_rs = e_rs; v.e_rt = e_rt; v.e_en = e_en; v.e_data = e_data; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a, input logic en,
                                             input logic [4:0] wr, input logic [31:0] d);
    if (a == 5'd0)            return 32'd0;
    else if (en && a == wr)   return d;
    else                      return mdl[a];
  endfunction

  // One clock of stimulus: drive, check combinational outputs mid-cycle,
  // advance the model, then cross the edge.
  task automatic apply(input vec_t v, input bit use_tab);
    logic [31:0] x_data, x_rs, x_rt, x_cnt;
    logic        x_en;
    rst               = v.rst;
    bus.RegwriteWb    = v.rw;
    bus.MemtoRegWb    = v.memto;
    bus.DatacWb       = v.datac;
    bus.write_reg_wb  = v.wr;
    bus.rs_addr       = v.rs;
    bus.rt_addr       = v.rt;
    bus.AluResWb      = v.alu;
    bus.read_data_wb  = v.rd;
    bus.pc_wb         = v.pc;
    #2;
    x_data = v.datac ? v.pc + 32'd8 : (v.memto ? v.rd : v.alu);
    x_en   = v.rw && !v.rst && (v.wr != 5'd0);
    if (use_tab) begin
      x_rs = v.e_rs; x_rt = v.e_rt; x_cnt = v.e_cnt;
      x_en = v.e_en; x_data = v.e_data;
    end else begin
      x_rs  = model_read(v.rs, x_en, v.wr, x_data);
      x_rt  = model_read(v.rt, x_en, v.wr, x_data);
      x_cnt = mcnt;
    end
    chk("rs_data",  bus.rs_data, x_rs);
    chk("rt_data",  bus.rt_data, x_rt);
    chk("wb_en",    {31'd0, bus.wb_en}, {31'd0, x_en});
    chk("wb_reg",   {27'd0, bus.wb_reg}, {27'd0, v.wr});
    if (use_tab || x_en) chk("wb_data", bus.wb_data, x_data);
    chk("wb_count", bus.wb_count, x_cnt);
    chk("wb_count4", {28'd0, bus4.wb_count}, {28'd0, x_cnt[3:0]});
    if (v.rst) begin
      for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
      mcnt = 32'd0;
    end else if (x_en) begin
      mdl[v.wr] = v.datac ? v.pc + 32'd8 : (v.memto ? v.rd : v.alu);
      mcnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    vec_t v;
    v = mk(1,0,0,0, 0,0,0, 0,0,0, 0,0, 0,0,0);
    rst = 1'b1;
    bus.RegwriteWb = 1'b0; bus.MemtoRegWb = 1'b0; bus.DatacWb = 1'b0;
    bus.write_reg_wb = '0; bus.rs_addr = '0; bus.rt_addr = '0;
    bus.AluResWb = '0; bus.read_data_wb = '0; bus.pc_wb = '0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    mcnt = 32'd0;
    v.rst = 1'b0;
    rst = v.rst;
  endtask

  vec_t tab [12];

  initial begin
    //        rst rw mt dc  wr rs rt  alu           rd            pc            e_rs          e_rt          en e_data        cnt
    tab[0]  = mk(0,1,0,0,  5, 5, 0, 32'hDEADBEEF, 32'h0,        32'h0,        32'hDEADBEEF, 32'h0,        1, 32'hDEADBEEF, 0);
    tab[1]  = mk(1,0,0,0,  0, 5, 5, 32'h0,        32'h0,        32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 0, 32'h0,        1);
    tab[2]  = mk(0,0,0,0,  0, 5, 0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        0, 32'h0,        0);
    tab[3]  = mk(0,1,1,1, 31,31, 1, 32'h11,       32'h22,       32'h400,      32'h408,      32'h0,        1, 32'h408,      0);
    tab[4]  = mk(0,0,1,0, 31,31,31, 32'h11,       32'h22,       32'h400,      32'h408,      32'h408,      0, 32'h22,       1);
    tab[5]  = mk(0,1,0,0,  0, 0,31, 32'hFFFF,     32'h0,        32'h0,        32'h0,        32'h408,      0, 32'hFFFF,     1);
    tab[6]  = mk(0,1,0,0,  7, 7, 7, 32'hCAFE,     32'h0,        32'h0,        32'hCAFE,     32'hCAFE,     1, 32'hCAFE,     1);
    tab[7]  = mk(1,1,0,0,  3, 3, 7, 32'h55,       32'h0,        32'h0,        32'h0,        32'hCAFE,     0, 32'h55,       2);
    tab[8]  = mk(0,0,0,0,  0, 3, 7, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        0, 32'h0,        0);
    tab[9]  = mk(0,1,0,1,  2, 2, 0, 32'h0,        32'h0,        32'hFFFFFFFC, 32'h4,        32'h0,        1, 32'h4,        0);
    tab[10] = mk(0,1,1,0,  2, 2, 2, 32'h0,        32'h12345678, 32'h0,        32'h12345678, 32'h12345678, 1, 32'h12345678, 1);
    tab[11] = mk(0,0,0,0,  0, 2,31, 32'h0,        32'h0,        32'h0,        32'h12345678, 32'h0,        0, 32'h0,        2);

    @(posedge clk);
    #1;
    do_reset();

    // Preload r5 so the first reset in the table has something to clear.
    for (int i = 0; i < 12; i++) apply(tab[i], 1'b1);

    // Random traffic with occasional mid-stream resets.
    for (int n = 0; n < 400; n++) begin
      vec_t v;
      v = mk(0,0,0,0, 0,0,0, 0,0,0, 0,0, 0,0,0);
      v.rst   = ($urandom_range(0, 39) == 0);
      v.rw    = ($urandom_range(0, 3) != 0);
      v.memto = 1'($urandom_range(0, 1));
      v.datac = ($urandom_range(0, 4) == 0);
      v.wr    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      v.rs    = ($urandom_range(0, 2) == 0) ? v.wr : 5'($urandom_range(0, 31));
      v.rt    = ($urandom_range(0, 2) == 0) ? v.wr : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 5) == 0) v.rt = v.rs;
      v.alu   = $urandom;
      v.rd    = $urandom;
      v.pc    = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF8 + 32'($urandom_range(0, 7)) : $urandom;
      apply(v, 1'b0);
    end

    // 17 commits to r1: the 4-bit counter wraps to 1, the wide one reads 17.
    do_reset();
    for (int n = 0; n < 17; n++)
      apply(mk(0,1,0,0, 1,1,0, 32'(n),0,0, 0,0, 0,0,0), 1'b0);
    apply(mk(0,0,0,0, 0,1,1, 0,0,0, 0,0, 0,0,0), 1'b0);
    chk("wrap_count32", bus.wb_count, 32'd17);
    chk("wrap_count4", {28'd0, bus4.wb_count}, 32'd1);
    chk("wrap_r1", bus.rs_data, 32'd16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
